// File: rtl/decrement_timer_pkg.sv
// -----------------------------------------------------------------------------
// decrement_timer_pkg
//
// Purpose : shared definitions for the decrement timer: the default counter
//           width, the FSM state encoding and a small state-decode helper.
//
// Contents:
//   DEFAULT_WIDTH  default width of the count, load value and step
//   state_t        FSM state encoding (IDLE, LOADED, RUN, PAUSED, DONE)
//   is_busy()      true for the states in which the timer owns the count
// -----------------------------------------------------------------------------
package decrement_timer_pkg;

    localparam int DEFAULT_WIDTH = 26;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOADED = 3'd1,
        ST_RUN    = 3'd2,
        ST_PAUSED = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // RUN and PAUSED are the only states in which a new load is refused.
    function automatic logic is_busy(input state_t s);
        return (s == ST_RUN) || (s == ST_PAUSED);
    endfunction

endpackage : decrement_timer_pkg

// File: rtl/decrement_timer_sat_sub.sv
// -----------------------------------------------------------------------------
// sat_sub
//
// Purpose : unsigned subtractor that saturates at zero instead of wrapping.
//
// Ports:
//   a       input  WIDTH  minuend
//   b       input  WIDTH  subtrahend
//   diff    output WIDTH  a - b when a >= b, otherwise 0
//   borrow  output 1      high when b > a (the result was clamped)
// -----------------------------------------------------------------------------
module sat_sub #(
    parameter int WIDTH = 26
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    // One extra bit on the left captures the borrow out of the MSB.
    logic [WIDTH:0] w_ext;

    always_comb begin
        w_ext  = {1'b0, a} - {1'b0, b};
        borrow = w_ext[WIDTH];
        diff   = w_ext[WIDTH] ? '0 : w_ext[WIDTH-1:0];
    end

endmodule : sat_sub

// File: rtl/decrement_timer.sv
// -----------------------------------------------------------------------------
// decrement_timer
//
// Purpose : loadable down-counter. A value is loaded through a valid/ready
//           handshake, then counted down by a per-cycle step while running.
//           Counting can be paused and resumed, and aborted at any time.
//           Reaching zero raises a one-cycle done pulse and, if the last step
//           was larger than what remained, a sticky underflow flag.
//
// Handshake: a load transfers on a rising edge where load_valid && load_ready.
//           load_ready is a pure decode of the state (high in IDLE, LOADED and
//           DONE) and never depends on load_valid; load_valid seen while
//           load_ready is low is dropped, it is not held pending.
//
// Ports:
//   clk          input  1      single clock, rising edge
//   GlobalReset  input  1      asynchronous active-low reset
//   load_valid   input  1      load request
//   load_value   input  WIDTH  value to load
//   load_ready   output 1      a load is accepted this cycle
//   decrement    input  WIDTH  step subtracted on each RUN cycle
//   start        input  1      begin / resume counting
//   pause        input  1      suspend counting
//   abort        input  1      return to IDLE, overrides everything
//   Out          output WIDTH  registered count
//   busy         output 1      high in RUN or PAUSED
//   done         output 1      one-cycle pulse on reaching zero
//   underflow    output 1      sticky: final step exceeded remaining count
//   o_dbg_state  output 3      current FSM state encoding (observation only)
// -----------------------------------------------------------------------------
module decrement_timer
    import decrement_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             GlobalReset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_ready,
    input  logic [WIDTH-1:0] decrement,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] Out,
    output logic             busy,
    output logic             done,
    output logic             underflow,
    output logic [2:0]       o_dbg_state
);

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    state_t           r_state;
    logic [WIDTH-1:0] r_out;
    logic             r_done;
    logic             r_underflow;

    // -------------------------------------------------------------------------
    // Next-state values and datapath wires
    // -------------------------------------------------------------------------
    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_out_nxt;
    logic             w_done_nxt;
    logic             w_underflow_nxt;
    logic [WIDTH-1:0] w_diff;
    logic             w_borrow;
    logic             w_load_fire;
    logic             w_reaches_zero;

    sat_sub #(
        .WIDTH (WIDTH)
    ) u_sat_sub (
        .a      (r_out),
        .b      (decrement),
        .diff   (w_diff),
        .borrow (w_borrow)
    );

    assign load_ready  = !is_busy(r_state);
    assign busy        = is_busy(r_state);
    assign w_load_fire = load_valid && load_ready;

    // Out <= decrement: either the step overshoots (borrow) or lands exactly on
    // zero. A zero count with a zero step also lands here, which finishes a
    // timer that was started from zero.
    assign w_reaches_zero = w_borrow || (w_diff == '0);

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_out_nxt       = r_out;
        w_done_nxt      = 1'b0;
        w_underflow_nxt = r_underflow;

        if (abort) begin
            w_state_nxt     = ST_IDLE;
            w_out_nxt       = '0;
            w_underflow_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_load_fire) begin
                        w_state_nxt     = ST_LOADED;
                        w_out_nxt       = load_value;
                        w_underflow_nxt = 1'b0;
                    end
                end

                // A load in the same cycle as start wins; the timer re-loads
                // and waits for another start.
                ST_LOADED: begin
                    if (w_load_fire) begin
                        w_out_nxt       = load_value;
                        w_underflow_nxt = 1'b0;
                    end else if (start) begin
                        w_state_nxt = ST_RUN;
                    end
                end

                // pause is checked first so a paused cycle never subtracts.
                ST_RUN: begin
                    if (pause) begin
                        w_state_nxt = ST_PAUSED;
                    end else if (w_reaches_zero) begin
                        w_state_nxt     = ST_DONE;
                        w_out_nxt       = '0;
                        w_done_nxt      = 1'b1;
                        w_underflow_nxt = w_borrow;
                    end else begin
                        w_out_nxt = w_diff;
                    end
                end

                ST_PAUSED: begin
                    if (start && !pause) begin
                        w_state_nxt = ST_RUN;
                    end
                end

                // Out is already zero here; start is ignored.
                ST_DONE: begin
                    if (w_load_fire) begin
                        w_state_nxt     = ST_LOADED;
                        w_out_nxt       = load_value;
                        w_underflow_nxt = 1'b0;
                    end
                end

                default: begin
                    w_state_nxt     = ST_IDLE;
                    w_out_nxt       = '0;
                    w_underflow_nxt = 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            r_state     <= ST_IDLE;
            r_out       <= '0;
            r_done      <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out       <= w_out_nxt;
            r_done      <= w_done_nxt;
            r_underflow <= w_underflow_nxt;
        end
    end

    assign Out         = r_out;
    assign done        = r_done;
    assign underflow   = r_underflow;
    assign o_dbg_state = r_state;

endmodule : decrement_timer

// File: tb/tb_decrement_timer.sv
module tb_decrement_timer;
  import decrement_timer_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         clk;
  logic         rst_n;
  logic         load_valid;
  logic [W-1:0] load_value;
  logic         load_ready;
  logic [W-1:0] dec;
  logic         start;
  logic         pause;
  logic         abort;
  logic [W-1:0] out;
  logic         busy;
  logic         done;
  logic         underflow;
  logic [2:0]   dbg_state;

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  decrement_timer #(.WIDTH(W)) dut (
    .clk         (clk),
    .GlobalReset (rst_n),
    .load_valid  (load_valid),
    .load_value  (load_value),
    .load_ready  (load_ready),
    .decrement   (dec),
    .start       (start),
    .pause       (pause),
    .abort       (abort),
    .Out         (out),
    .busy        (busy),
    .done        (done),
    .underflow   (underflow),
    .o_dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic         lv;
    logic [W-1:0] lval;
    logic [W-1:0] dec;
    logic         st;
    logic         pa;
    logic         ab;
    logic [W-1:0] e_out;
    logic         e_busy;
    logic         e_done;
    logic         e_uf;
    logic         e_rdy;
    state_t       e_st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic lv, input int lval, input int d,
                             input logic st, input logic pa, input logic ab,
                             input int e_out, input logic e_busy, input logic e_done,
                             input logic e_uf, input logic e_rdy, input state_t e_st);
    vec_t r;
    r.lv = lv; r.lval = W'(lval); r.dec = W'(d);
    r.st = st; r.pa = pa; r.ab = ab;
    r.e_out = W'(e_out); r.e_busy = e_busy; r.e_done = e_done;
    r.e_uf = e_uf; r.e_rdy = e_rdy; r.e_st = e_st;
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic lv, input int lval, input int d,
                       input logic st, input logic pa, input logic ab);
    load_valid = lv;
    load_value = W'(lval);
    dec        = W'(d);
    start      = st;
    pause      = pa;
    abort      = ab;
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input int tag, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, tag, act, exp);
    end
  endtask

  task automatic check_all(input int tag, input int e_out, input logic e_busy,
                           input logic e_done, input logic e_uf, input logic e_rdy,
                           input state_t e_st);
    check("out",        tag, 32'(out),       32'(W'(e_out)));
    check("busy",       tag, 32'(busy),      32'(e_busy));
    check("done",       tag, 32'(done),      32'(e_done));
    check("underflow",  tag, 32'(underflow), 32'(e_uf));
    check("load_ready", tag, 32'(load_ready), 32'(e_rdy));
    check("state",      tag, 32'(dbg_state), 32'(e_st));
  endtask

  task automatic tick_and_check(input int tag, input int e_out, input logic e_busy,
                                input logic e_done, input logic e_uf, input logic e_rdy,
                                input state_t e_st);
    @(posedge clk);
    #1;
    check_all(tag, e_out, e_busy, e_done, e_uf, e_rdy, e_st);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    //                lv lval dec st pa ab   out busy done uf rdy state
    // load 10 step 3: 10,7,4,1,0 with underflow
    vecs.push_back(v(1, 10, 3, 0, 0, 0,  10, 0, 0, 0, 1, ST_LOADED));
    vecs.push_back(v(0,  0, 3, 1, 0, 0,  10, 1, 0, 0, 0, ST_RUN));
    vecs.push_back(v(0,  0, 3, 0, 0, 0,   7, 1, 0, 0, 0, ST_RUN));
    vecs.push_back(v(0,  0, 3, 0, 0, 0,   4, 1, 0, 0, 0, ST_RUN));
    vecs.push_back(v(0,  0, 3, 0, 0, 0,   1, 1, 0, 0, 0, ST_RUN));
    vecs.push_back(v(0,  0, 3, 0, 0, 0,   0, 0, 1, 1, 1, ST_DONE));
    vecs.push_back(v(0,  0, 3, 0, 0, 0,   0, 0, 0, 1, 1, ST_DONE));
    vecs.push_back(v(0,  0, 3, 1, 0, 0,   0, 0, 0, 1, 1, ST_DONE));
    // load 9 step 3: 9,6,3,0 exact, no underflow
    vecs.push_back(v(1,  9, 3, 0, 0, 0,   9, 0, 0, 0, 1, ST_LOADED));
    vecs.push_back(v(0,  0, 3, 1, 0, 0,   9, 1, 0, 0, 0, ST_RUN));
    vecs.push_back(v(0,  0, 3, 0, 0, 0,   6, 1, 0, 0, 0, ST_RUN));
    vecs.push_back(v(0,  0, 3, 0, 0, 0,   3, 1, 0, 0, 0, ST_RUN));
    vecs.push_back(v(0,  0, 3, 0, 0, 0,   0, 0, 1, 0, 1, ST_DONE));
    vecs.push_back(v(0,  0, 3, 0, 0, 0,   0, 0, 0, 0, 1, ST_DONE));
    // load 20 step 5, pause at 15 for three cycles, start+pause stays paused
    vecs.push_back(v(1, 20, 5, 0, 0, 0,  20, 0, 0, 0, 1, ST_LOADED));
    vecs.push_back(v(0,  0, 5, 1, 0, 0,  20, 1, 0, 0, 0, ST_RUN));
    vecs.push_back(v(0,  0, 5, 0, 0, 0,  15, 1, 0, 0, 0, ST_RUN));
    vecs.push_back(v(0,  0, 5, 0, 1, 0,  15, 1, 0, 0, 0, ST_PAUSED));
    vecs.push_back(v(0,  0, 5, 0, 1, 0,  15, 1, 0, 0, 0, ST_PAUSED));
    vecs.push_back(v(0,  0, 5, 0, 1, 0,  15, 1, 0, 0, 0, ST_PAUSED));
    vecs.push_back(v(0,  0, 5, 1, 1, 0,  15, 1, 0, 0, 0, ST_PAUSED));
    vecs.push_back(v(0,  0, 5, 1, 0, 0,  15, 1, 0, 0, 0, ST_RUN));
    vecs.push_back(v(0,  0, 5, 0, 0, 0,  10, 1, 0, 0, 0, ST_RUN));
    vecs.push_back(v(0,  0, 5, 0, 0, 0,   5, 1, 0, 0, 0, ST_RUN));
    vecs.push_back(v(0,  0, 5, 0, 0, 0,   0, 0, 1, 0, 1, ST_DONE));
    vecs.push_back(v(0,  0, 5, 0, 0, 0,   0, 0, 0, 0, 1, ST_DONE));
    // load ignored during RUN, then abort mid-RUN
    vecs.push_back(v(1, 30, 2, 0, 0, 0,  30, 0, 0, 0, 1, ST_LOADED));
    vecs.push_back(v(0,  0, 2, 1, 0, 0,  30, 1, 0, 0, 0, ST_RUN));
    vecs.push_back(v(0,  0, 2, 0, 0, 0,  28, 1, 0, 0, 0, ST_RUN));
    vecs.push_back(v(1,  7, 2, 0, 0, 0,  26, 1, 0, 0, 0, ST_RUN));
    vecs.push_back(v(0,  0, 2, 0, 0, 1,   0, 0, 0, 0, 1, ST_IDLE));
    vecs.push_back(v(0,  0, 2, 0, 0, 0,   0, 0, 0, 0, 1, ST_IDLE));
    // load wins over start; zero step holds; pause beats start in RUN; abort from PAUSED
    vecs.push_back(v(1,  8, 0, 0, 0, 0,   8, 0, 0, 0, 1, ST_LOADED));
    vecs.push_back(v(1,  6, 0, 1, 0, 0,   6, 0, 0, 0, 1, ST_LOADED));
    vecs.push_back(v(0,  0, 0, 1, 0, 0,   6, 1, 0, 0, 0, ST_RUN));
    vecs.push_back(v(0,  0, 0, 0, 0, 0,   6, 1, 0, 0, 0, ST_RUN));
    vecs.push_back(v(0,  0, 2, 0, 0, 0,   4, 1, 0, 0, 0, ST_RUN));
    vecs.push_back(v(0,  0, 2, 1, 1, 0,   4, 1, 0, 0, 0, ST_PAUSED));
    vecs.push_back(v(0,  0, 2, 1, 0, 1,   0, 0, 0, 0, 1, ST_IDLE));
    // load 0 then start: RUN then DONE, no underflow; start in DONE ignored
    vecs.push_back(v(1,  0, 0, 0, 0, 0,   0, 0, 0, 0, 1, ST_LOADED));
    vecs.push_back(v(0,  0, 0, 1, 0, 0,   0, 1, 0, 0, 0, ST_RUN));
    vecs.push_back(v(0,  0, 0, 0, 0, 0,   0, 0, 1, 0, 1, ST_DONE));
    vecs.push_back(v(0,  0, 0, 1, 0, 0,   0, 0, 0, 0, 1, ST_DONE));
    vecs.push_back(v(1,  9, 0, 0, 0, 1,   0, 0, 0, 0, 1, ST_IDLE));
    // all-ones step saturates to zero; load from DONE clears underflow
    vecs.push_back(v(1,  5, -1, 0, 0, 0,  5, 0, 0, 0, 1, ST_LOADED));
    vecs.push_back(v(0,  0, -1, 1, 0, 0,  5, 1, 0, 0, 0, ST_RUN));
    vecs.push_back(v(0,  0, -1, 0, 0, 0,  0, 0, 1, 1, 1, ST_DONE));
    vecs.push_back(v(1,  3, -1, 0, 0, 0,  3, 0, 0, 0, 1, ST_LOADED));
    vecs.push_back(v(0,  0, 0, 0, 0, 1,   0, 0, 0, 0, 1, ST_IDLE));

    // Reset state, observed before any clock edge
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #3;
    check_all(-1, 0, 0, 0, 0, 1, ST_IDLE);

    // Release, first edge is an ordinary IDLE cycle
    @(negedge clk);
    rst_n = 1'b1;
    tick_and_check(0, 0, 0, 0, 0, 1, ST_IDLE);

    // Table
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].lv, int'(vecs[i].lval), int'(vecs[i].dec),
            vecs[i].st, vecs[i].pa, vecs[i].ab);
      @(posedge clk);
      #1;
      check("out",        i + 1, 32'(out),        32'(vecs[i].e_out));
      check("busy",       i + 1, 32'(busy),       32'(vecs[i].e_busy));
      check("done",       i + 1, 32'(done),       32'(vecs[i].e_done));
      check("underflow",  i + 1, 32'(underflow),  32'(vecs[i].e_uf));
      check("load_ready", i + 1, 32'(load_ready), 32'(vecs[i].e_rdy));
      check("state",      i + 1, 32'(dbg_state),  32'(vecs[i].e_st));
    end

    // Reset asserted mid-RUN at Out = 12: immediate clear, no done pulse
    @(negedge clk);
    drive(1, 20, 4, 0, 0, 0);
    tick_and_check(100, 20, 0, 0, 0, 1, ST_LOADED);
    @(negedge clk);
    drive(0, 0, 4, 1, 0, 0);
    tick_and_check(101, 20, 1, 0, 0, 0, ST_RUN);
    @(negedge clk);
    drive(0, 0, 4, 0, 0, 0);
    tick_and_check(102, 16, 1, 0, 0, 0, ST_RUN);
    tick_and_check(103, 12, 1, 0, 0, 0, ST_RUN);
    #2;
    rst_n = 1'b0;
    #1;
    check_all(104, 0, 0, 0, 0, 1, ST_IDLE);
    tick_and_check(105, 0, 0, 0, 0, 1, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 4, 4, 0, 0, 0);
    tick_and_check(106, 4, 0, 0, 0, 1, ST_LOADED);
    @(negedge clk);
    drive(0, 0, 4, 1, 0, 0);
    tick_and_check(107, 4, 1, 0, 0, 0, ST_RUN);
    @(negedge clk);
    drive(0, 0, 4, 0, 0, 0);
    tick_and_check(108, 0, 0, 1, 0, 1, ST_DONE);
    tick_and_check(109, 0, 0, 0, 0, 1, ST_DONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_decrement_timer
